// File: rtl/uart_receiver.sv
// 8N1 UART receiver, oversampled at CLKS_PER_BIT; optional rx synchronizer via UART_RX_SYNC_EN.
// Latency: valid at E0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+2 with UART_RX_SYNC_EN).
// Backpressure: none; data must be taken on the valid strobe and is overwritten by the next good frame.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            rs;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Reset to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rs = sync_q[1];
`else
    assign rs = rx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_HIGH;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                WAIT_HIGH: begin
                    if (rs) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!rs) begin
                        state <= START;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                START: begin
                    // Mid-start-bit check rejects glitches shorter than half a bit.
                    if (cnt == CW'(H - 1)) begin
                        cnt <= '0;
                        if (rs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rs;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt  <= '0;
                        busy <= 1'b0;
                        if (rs) begin
                            data  <= shreg;
                            valid <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // Line held low (break): wait for idle before arming again.
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= WAIT_HIGH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized frame bench for uart_receiver with a timing/data reference model.
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_SYNC_EN
    localparam int ADJ = 2;
`else
    localparam int ADJ = 0;
`endif
    localparam int VLAT = H + 9 * CPB + ADJ;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int vcyc[$];
    int vdat[$];
    int ecyc[$];
    int rises = 0;
    int rise_cyc = -1;
    int fall_cyc = -1;
    int overlap = 0;
    logic busy_prev = 1'b0;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge; cyc then equals the index of the preceding rising edge.
    always @(negedge clk) begin
        if (valid) begin
            vcyc.push_back(cyc);
            vdat.push_back(int'(data));
        end
        if (frame_err) ecyc.push_back(cyc);
        if (valid && frame_err) overlap++;
        if (busy && !busy_prev) begin
            rises++;
            rise_cyc = cyc;
        end
        if (!busy && busy_prev) fall_cyc = cyc;
        busy_prev = busy;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        vcyc.delete();
        vdat.delete();
        ecyc.delete();
        rises = 0;
    endtask

    // Drives the first ncyc cycles of an 8N1 frame; e0 is the first edge that sees the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int ncyc, output int e0);
        logic [9:0] f;
        f  = {stop, b, 1'b0};
        e0 = cyc + 1;
        for (int k = 0; k < ncyc; k++) begin
            rx = f[k / CPB];
            tick(1);
        end
        rx = 1'b1;
    endtask

    task automatic check_good(input string tag, input int e0, input logic [7:0] b);
        chk({tag, "_nvalid"}, vcyc.size(), 1);
        if (vcyc.size() > 0) begin
            chk({tag, "_vtime"}, vcyc[0], e0 + VLAT);
            chk({tag, "_vdata"}, vdat[0], int'(b));
        end
        chk({tag, "_nferr"}, ecyc.size(), 0);
    endtask

    initial begin
        int e0;
        int e0b;
        logic [7:0] b;
        logic [7:0] last;

        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        chk("rst_data", data, 8'h00);
        chk("rst_flags", {valid, frame_err, busy}, 3'b000);
        rst_n = 1'b1;
        tick(4);
        chk("idle_flags", {valid, frame_err, busy}, 3'b000);

        clear_log();
        send_frame(8'hA5, 1'b1, 10 * CPB, e0);
        tick(2);
        check_good("a5", e0, 8'hA5);
        chk("a5_busy_rise", rise_cyc, e0 + ADJ);
        chk("a5_busy_fall", fall_cyc, e0 + VLAT);
        chk("a5_held", data, 8'hA5);

        clear_log();
        send_frame(8'h00, 1'b1, 10 * CPB, e0);
        send_frame(8'hFF, 1'b1, 10 * CPB, e0b);
        tick(2);
        chk("b2b_nvalid", vcyc.size(), 2);
        if (vcyc.size() == 2) begin
            chk("b2b_first_time", vcyc[0], e0 + VLAT);
            chk("b2b_spacing", vcyc[1] - vcyc[0], 160);
            chk("b2b_d0", vdat[0], 32'h00);
            chk("b2b_d1", vdat[1], 32'hFF);
        end

        clear_log();
        rx = 1'b0;
        e0 = cyc + 1;
        tick(4);
        rx = 1'b1;
        tick(20);
        chk("fs_nvalid", vcyc.size(), 0);
        chk("fs_nferr", ecyc.size(), 0);
        chk("fs_busy_fall", fall_cyc, e0 + H + ADJ);
        chk("fs_data", data, 8'hFF);

        clear_log();
        send_frame(8'h3C, 1'b0, 9 * CPB, e0);
        rx = 1'b0;
        tick(40);
        rx = 1'b1;
        tick(3);
        chk("fe_nferr", ecyc.size(), 1);
        if (ecyc.size() > 0) chk("fe_time", ecyc[0], e0 + VLAT);
        chk("fe_nvalid", vcyc.size(), 0);
        chk("fe_data", data, 8'hFF);
        chk("fe_no_restart", rises, 1);
        clear_log();
        send_frame(8'h81, 1'b1, 10 * CPB, e0);
        tick(2);
        check_good("after_fe", e0, 8'h81);

        clear_log();
        send_frame(8'h5A, 1'b1, 60, e0);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        chk("mid_rst_data", data, 8'h00);
        chk("mid_rst_flags", {valid, frame_err, busy}, 3'b000);
        tick(3);
        rst_n = 1'b1;
        tick(200);
        chk("post_rst_nvalid", vcyc.size(), 0);
        chk("post_rst_nferr", ecyc.size(), 0);
        chk("post_rst_data", data, 8'h00);
        clear_log();
        send_frame(8'h5A, 1'b1, 10 * CPB, e0);
        tick(2);
        check_good("after_rst", e0, 8'h5A);

        last = 8'h5A;
        for (int n = 0; n < 16; n++) begin
            clear_log();
            tick($urandom_range(0, 3));
            b = 8'($urandom);
            send_frame(b, 1'b1, 10 * CPB, e0);
            check_good("rand", e0, b);
            last = b;
        end
        tick(12);
        chk("rand_final_data", data, last);
        chk("no_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
